// File: rtl/arm_pipeline.sv
// rtl/arm_pipeline.sv - five-stage ARM control-signal pipeline with instruction ROM

// Instruction ROM: combinational word read, contents loaded from outside.
module Instruction_Memory_ROM (
    output logic [31:0] I,
    input  logic [7:0]  A
);
    logic [31:0] Mem [0:255];

    assign I = Mem[A];
endmodule

// ID-stage decoder: instruction word to control signals.
module control_unit (
    input  logic [31:0] instr,
    output logic [3:0]  ID_ALU_op,
    output logic [1:0]  ID_AM,
    output logic        ID_S,
    output logic        ID_B,
    output logic        ID_BL,
    output logic        ID_Load,
    output logic        RF_ENABLE,
    output logic        ID_MEM_SIZE,
    output logic        ID_MEM_WRITE,
    output logic        ID_MEM_E
);
    // Decode by instruction class; the all-zero word and unknown classes stay NOP.
    always_comb begin
        ID_ALU_op    = 4'b0000;
        ID_AM        = 2'b00;
        ID_S         = 1'b0;
        ID_B         = 1'b0;
        ID_BL        = 1'b0;
        ID_Load      = 1'b0;
        RF_ENABLE    = 1'b0;
        ID_MEM_SIZE  = 1'b0;
        ID_MEM_WRITE = 1'b0;
        ID_MEM_E     = 1'b0;
        if (instr != 32'h0000_0000) begin
            if (instr[27:26] == 2'b00) begin
                ID_ALU_op = instr[24:21];
                ID_AM     = instr[25] ? 2'b00 : 2'b11;
                ID_S      = instr[20];
                // Compare/test opcodes only set flags, no register writeback
                RF_ENABLE = (instr[24:23] != 2'b10);
            end else if (instr[27:26] == 2'b01) begin
                ID_ALU_op    = instr[23] ? 4'b0100 : 4'b0010;
                ID_AM        = instr[25] ? 2'b11 : 2'b10;
                ID_Load      = instr[20];
                RF_ENABLE    = instr[20];
                ID_MEM_WRITE = ~instr[20];
                ID_MEM_SIZE  = instr[22];
                ID_MEM_E     = 1'b1;
            end else if (instr[27:25] == 3'b101) begin
                ID_B      = 1'b1;
                ID_BL     = instr[24];
                RF_ENABLE = instr[24];
            end
        end
    end
endmodule

// ID->EX pipeline register for the control fields.
module ex_mem_reg (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] ID_ALU_op,
    input  logic [1:0] ID_AM,
    input  logic       ID_S,
    input  logic       ID_Load,
    input  logic       RF_ENABLE,
    input  logic       ID_MEM_SIZE,
    input  logic       ID_MEM_WRITE,
    input  logic       ID_MEM_E,
    output logic [3:0] EX_opcode,
    output logic [1:0] EX_am,
    output logic       EX_S,
    output logic       EX_Tload,
    output logic       EX_rf_e,
    output logic       EX_size,
    output logic       EX_rw,
    output logic       EX_e
);
    // Latch decoded controls each edge; reset flushes to NOP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            EX_opcode <= 4'b0000;
            EX_am     <= 2'b00;
            EX_S      <= 1'b0;
            EX_Tload  <= 1'b0;
            EX_rf_e   <= 1'b0;
            EX_size   <= 1'b0;
            EX_rw     <= 1'b0;
            EX_e      <= 1'b0;
        end else begin
            EX_opcode <= ID_ALU_op;
            EX_am     <= ID_AM;
            EX_S      <= ID_S;
            EX_Tload  <= ID_Load;
            EX_rf_e   <= RF_ENABLE;
            EX_size   <= ID_MEM_SIZE;
            EX_rw     <= ID_MEM_WRITE;
            EX_e      <= ID_MEM_E;
        end
    end
endmodule

// EX->MEM pipeline register for the memory-stage controls.
module mem_wb_reg (
    input  logic clk,
    input  logic reset,
    input  logic EX_Tload,
    input  logic EX_rf_e,
    input  logic EX_size,
    input  logic EX_rw,
    input  logic EX_e,
    output logic MEM_Load,
    output logic MEM_rf_e,
    output logic MEM_size,
    output logic MEM_rw,
    output logic MEM_e
);
    // Forward the memory and writeback controls one stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            MEM_Load <= 1'b0;
            MEM_rf_e <= 1'b0;
            MEM_size <= 1'b0;
            MEM_rw   <= 1'b0;
            MEM_e    <= 1'b0;
        end else begin
            MEM_Load <= EX_Tload;
            MEM_rf_e <= EX_rf_e;
            MEM_size <= EX_size;
            MEM_rw   <= EX_rw;
            MEM_e    <= EX_e;
        end
    end
endmodule

// Top: fetch, decode and control-field pipeline down to writeback enable.
module arm_pipeline (
    input  logic        clk,
    input  logic        reset,
    output logic [7:0]  instr_address,
    output logic [31:0] pc_out
);
    logic [31:0] PC;
    logic [31:0] instr_if_id;
    logic [31:0] rom_data;
    logic [3:0]  ID_ALU_op;
    logic [1:0]  ID_AM;
    logic        ID_S, ID_B, ID_BL, ID_Load, RF_ENABLE;
    logic        ID_MEM_SIZE, ID_MEM_WRITE, ID_MEM_E;
    logic [3:0]  EX_opcode;
    logic [1:0]  EX_am;
    logic        EX_S, EX_Tload, EX_rf_e, EX_size, EX_rw, EX_e;
    logic        MEM_Load, MEM_rf_e, MEM_size, MEM_rw, MEM_e;
    logic        WB_rf_e;

    assign instr_address = PC[9:2];
    assign pc_out        = PC;

    Instruction_Memory_ROM instr_mem (
        .I (rom_data),
        .A (instr_address)
    );

    // Sequential fetch (no branch redirect) and IF/ID capture; PC wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC          <= 32'h0000_0000;
            instr_if_id <= 32'h0000_0000;
        end else begin
            PC          <= PC + 32'd4;
            instr_if_id <= rom_data;
        end
    end

    control_unit control_unit (
        .instr        (instr_if_id),
        .ID_ALU_op    (ID_ALU_op),
        .ID_AM        (ID_AM),
        .ID_S         (ID_S),
        .ID_B         (ID_B),
        .ID_BL        (ID_BL),
        .ID_Load      (ID_Load),
        .RF_ENABLE    (RF_ENABLE),
        .ID_MEM_SIZE  (ID_MEM_SIZE),
        .ID_MEM_WRITE (ID_MEM_WRITE),
        .ID_MEM_E     (ID_MEM_E)
    );

    ex_mem_reg EX_MEM (
        .clk          (clk),
        .reset        (reset),
        .ID_ALU_op    (ID_ALU_op),
        .ID_AM        (ID_AM),
        .ID_S         (ID_S),
        .ID_Load      (ID_Load),
        .RF_ENABLE    (RF_ENABLE),
        .ID_MEM_SIZE  (ID_MEM_SIZE),
        .ID_MEM_WRITE (ID_MEM_WRITE),
        .ID_MEM_E     (ID_MEM_E),
        .EX_opcode    (EX_opcode),
        .EX_am        (EX_am),
        .EX_S         (EX_S),
        .EX_Tload     (EX_Tload),
        .EX_rf_e      (EX_rf_e),
        .EX_size      (EX_size),
        .EX_rw        (EX_rw),
        .EX_e         (EX_e)
    );

    mem_wb_reg MEM_WB (
        .clk      (clk),
        .reset    (reset),
        .EX_Tload (EX_Tload),
        .EX_rf_e  (EX_rf_e),
        .EX_size  (EX_size),
        .EX_rw    (EX_rw),
        .EX_e     (EX_e),
        .MEM_Load (MEM_Load),
        .MEM_rf_e (MEM_rf_e),
        .MEM_size (MEM_size),
        .MEM_rw   (MEM_rw),
        .MEM_e    (MEM_e)
    );

    // Writeback stage keeps only the register-file enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            WB_rf_e <= 1'b0;
        end else begin
            WB_rf_e <= MEM_rf_e;
        end
    end
endmodule

// File: tb/tb_arm_pipeline.sv
// tb/tb_arm_pipeline.sv - directed self-checking bench for arm_pipeline
`timescale 1ns/1ps
module tb_arm_pipeline;
    logic        clk;
    logic        reset;
    logic [7:0]  instr_address;
    logic [31:0] pc_out;
    int          checks;
    int          errors;

    arm_pipeline dut (
        .clk           (clk),
        .reset         (reset),
        .instr_address (instr_address),
        .pc_out        (pc_out)
    );

    // {ALU_op, AM, S, B, BL, Load, RF_ENABLE, MEM_SIZE, MEM_WRITE, MEM_E}
    wire [13:0] id_vec  = {dut.ID_ALU_op, dut.ID_AM, dut.ID_S, dut.ID_B, dut.ID_BL, dut.ID_Load,
                           dut.RF_ENABLE, dut.ID_MEM_SIZE, dut.ID_MEM_WRITE, dut.ID_MEM_E};
    // {opcode, am, S, Tload, rf_e, size, rw, e}
    wire [11:0] ex_vec  = {dut.EX_opcode, dut.EX_am, dut.EX_S, dut.EX_Tload, dut.EX_rf_e,
                           dut.EX_size, dut.EX_rw, dut.EX_e};
    // {Load, rf_e, size, rw, e}
    wire [4:0]  mem_vec = {dut.MEM_Load, dut.MEM_rf_e, dut.MEM_size, dut.MEM_rw, dut.MEM_e};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) dut.instr_mem.Mem[i] = 32'h0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({dut.PC, dut.instr_if_id} !== 64'h0) begin
            errors++; $display("FAIL reset_pc_ir got %h/%h want 0", dut.PC, dut.instr_if_id);
        end
        checks++;
        if ({ex_vec, mem_vec, dut.WB_rf_e} !== 18'h0) begin
            errors++; $display("FAIL reset_fields got %h/%h/%b want 0", ex_vec, mem_vec, dut.WB_rf_e);
        end
        dut.instr_mem.Mem[0] = 32'hE5912000;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({pc_out, dut.instr_if_id, ex_vec, mem_vec, dut.WB_rf_e} !== 82'h0) begin
            errors++; $display("FAIL reset_hold got pc=%h ir=%h want 0", pc_out, dut.instr_if_id);
        end
    endtask

    // ADD, LDR, STRB, BL, CMP then NOPs; every stage checked per edge.
    task automatic test_latency();
        logic [31:0] ins [0:7];
        logic [13:0] ide [0:7];
        logic [11:0] exe [0:7];
        logic [4:0]  meme[0:7];
        logic        wbe [0:7];
        ins = '{32'hE2811001, 32'hE5912000, 32'hE5C12000, 32'hEB000004, 32'hE3510000, 0, 0, 0};
        ide = '{14'b0100_00_0_0_0_0_1_0_0_0, 14'b0100_10_0_0_0_1_1_0_0_1, 14'b0100_10_0_0_0_0_0_1_1_1,
                14'b0000_00_0_1_1_0_1_0_0_0, 14'b1010_00_1_0_0_0_0_0_0_0, 0, 0, 0};
        exe = '{12'b0100_00_0_0_1_0_0_0, 12'b0100_10_0_1_1_0_0_1, 12'b0100_10_0_0_0_1_1_1,
                12'b0000_00_0_0_1_0_0_0, 12'b1010_00_1_0_0_0_0_0, 0, 0, 0};
        meme = '{5'b01000, 5'b11001, 5'b00111, 5'b01000, 5'b00000, 0, 0, 0};
        wbe  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        clear_rom();
        for (int i = 0; i < 8; i++) dut.instr_mem.Mem[i] = ins[i];
        release_reset();
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (pc_out !== 32'(4 * k) || instr_address !== 8'(k)) begin
                errors++; $display("FAIL lat_pc edge %0d got %h/%h want %h", k, pc_out, instr_address, 4 * k);
            end
            checks++;
            if (dut.instr_if_id !== ins[k-1] || id_vec !== ide[k-1]) begin
                errors++; $display("FAIL lat_id edge %0d got %h/%b want %h/%b", k, dut.instr_if_id, id_vec, ins[k-1], ide[k-1]);
            end
            checks++;
            if (ex_vec !== ((k >= 2) ? exe[k-2] : 12'h0)) begin
                errors++; $display("FAIL lat_ex edge %0d got %b", k, ex_vec);
            end
            checks++;
            if (mem_vec !== ((k >= 3) ? meme[k-3] : 5'h0)) begin
                errors++; $display("FAIL lat_mem edge %0d got %b", k, mem_vec);
            end
            checks++;
            if (dut.WB_rf_e !== ((k >= 4) ? wbe[k-4] : 1'b0)) begin
                errors++; $display("FAIL lat_wb edge %0d got %b", k, dut.WB_rf_e);
            end
        end
    endtask

    // Shifted-register ADD, load with U=0, unknown class (NOP).
    task automatic test_decode_misc();
        logic [31:0] ins [0:2];
        logic [13:0] ide [0:2];
        ins = '{32'hE0812003, 32'hE5112000, 32'hEE000000};
        ide = '{14'b0100_11_0_0_0_0_1_0_0_0, 14'b0010_10_0_0_0_1_1_0_0_1, 14'b0};
        clear_rom();
        for (int i = 0; i < 3; i++) dut.instr_mem.Mem[i] = ins[i];
        release_reset();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (id_vec !== ide[k]) begin
                errors++; $display("FAIL misc_dec %h got %b want %b", ins[k], id_vec, ide[k]);
            end
        end
    endtask

    task automatic test_zero_rom();
        clear_rom();
        release_reset();
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (pc_out !== 32'(4 * k) || {id_vec, ex_vec, mem_vec, dut.WB_rf_e} !== 32'h0) begin
                errors++; $display("FAIL zero_rom edge %0d got pc=%h id=%b ex=%b", k, pc_out, id_vec, ex_vec);
            end
        end
    endtask

    task automatic test_mid_reset();
        clear_rom();
        for (int i = 0; i < 8; i++) dut.instr_mem.Mem[i] = 32'hE5912000;
        release_reset();
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (mem_vec !== 5'b11001 || dut.WB_rf_e !== 1'b1) begin
            errors++; $display("FAIL mid_inflight got %b/%b want 11001/1", mem_vec, dut.WB_rf_e);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({pc_out, dut.instr_if_id, ex_vec, mem_vec, dut.WB_rf_e} !== 82'h0) begin
            errors++; $display("FAIL mid_flush got pc=%h ir=%h ex=%b mem=%b", pc_out, dut.instr_if_id, ex_vec, mem_vec);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({pc_out, dut.instr_if_id, ex_vec} !== 76'h0) begin
            errors++; $display("FAIL mid_hold got pc=%h ir=%h", pc_out, dut.instr_if_id);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (dut.instr_if_id !== 32'hE5912000 || pc_out !== 32'd4) begin
            errors++; $display("FAIL mid_refetch got ir=%h pc=%h want e5912000/4", dut.instr_if_id, pc_out);
        end
    endtask

    // PC 1024 indexes word 0 again.
    task automatic test_alias();
        clear_rom();
        dut.instr_mem.Mem[0] = 32'hE2811001;
        release_reset();
        repeat (256) @(posedge clk);
        #1;
        checks++;
        if (pc_out !== 32'd1024 || instr_address !== 8'd0) begin
            errors++; $display("FAIL alias_addr got pc=%h addr=%h want 400/00", pc_out, instr_address);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dut.instr_if_id !== 32'hE2811001 || dut.ID_ALU_op !== 4'b0100) begin
            errors++; $display("FAIL alias_fetch got ir=%h want e2811001", dut.instr_if_id);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_latency();
        test_decode_misc();
        test_zero_rom();
        test_mid_reset();
        test_alias();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
